clk_div_cfg_ctrl: RTL and testbench



---
 rtl/clk_div_cfg_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration sequencer in front of the runtime-configurable clock divider.
// Optional timeout monitor enabled by defining CLK_DIV_CFG_CTRL_TIMEOUT_EN.
module clk_div_cfg_ctrl #(
  parameter int DIV_VALUE_WIDTH   = 4,
  parameter int DEFAULT_DIV_VALUE = 0,
  parameter int SETTLE_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic [DIV_VALUE_WIDTH-1:0] div_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
  output logic                       busy_o,
  output logic                       pending_o,
  output logic                       timeout_o,
  input  logic                       timeout_clr_i
);

  localparam int SCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

  if (DEFAULT_DIV_VALUE < 0 || DEFAULT_DIV_VALUE >= (1 << DIV_VALUE_WIDTH)) begin : g_bad_default
    $error("DEFAULT_DIV_VALUE does not fit in DIV_VALUE_WIDTH bits");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_e;

  state_e                     state_q, state_d;
  logic                       pending_q, pending_d;
  logic [DIV_VALUE_WIDTH-1:0] pend_val_q, pend_val_d;
  logic [DIV_VALUE_WIDTH-1:0] div_q, div_d;
  logic                       div_valid_q, div_valid_d;
  logic [DIV_VALUE_WIDTH-1:0] cur_div_q, cur_div_d;
  logic [SCW-1:0]             settle_cnt_q, settle_cnt_d;
  logic                       accept;

  assign cfg_ready_o = ~pending_q;
  assign accept      = cfg_valid_i & ~pending_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_val_d   = pend_val_q;
    div_d        = div_q;
    div_valid_d  = div_valid_q;
    cur_div_d    = cur_div_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      IDLE: begin
        // A draining slot blocks new requests for this cycle (ready is low).
        if (pending_q) begin
          pending_d = 1'b0;
          if (pend_val_q != cur_div_q) begin
            div_d       = pend_val_q;
            div_valid_d = 1'b1;
            state_d     = REQ;
          end
        end else if (accept && (cfg_div_i != cur_div_q)) begin
          div_d       = cfg_div_i;
          div_valid_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          pending_d  = 1'b1;
          pend_val_d = cfg_div_i;
        end
        if (div_valid_q && div_ready_i) begin
          cur_div_d    = div_q;
          div_valid_d  = 1'b0;
          settle_cnt_d = '0;
          state_d      = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
        end
      end
      SETTLE: begin
        if (accept) begin
          pending_d  = 1'b1;
          pend_val_d = cfg_div_i;
        end
        if (int'(settle_cnt_q) == SETTLE_CYCLES - 1) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      pend_val_q   <= '0;
      div_q        <= DEF_DIV;
      div_valid_q  <= 1'b0;
      cur_div_q    <= DEF_DIV;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_val_q   <= pend_val_d;
      div_q        <= div_d;
      div_valid_q  <= div_valid_d;
      cur_div_q    <= cur_div_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign div_o       = div_q;
  assign div_valid_o = div_valid_q;
  assign cur_div_o   = cur_div_q;
  assign pending_o   = pending_q;
  assign busy_o      = (state_q != IDLE) | pending_q;

`ifdef CLK_DIV_CFG_CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;
  logic           timeout_set;

  // Held at zero outside REQ, so entering REQ always starts a fresh count;
  // the count saturates so the flag is raised once per stalled request.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_d   = timeout_q;
    timeout_set = 1'b0;
    if (state_q != REQ || div_ready_i) begin
      to_cnt_d = '0;
    end else if (int'(to_cnt_q) != TIMEOUT_CYCLES) begin
      to_cnt_d    = to_cnt_q + TCW'(1);
      timeout_set = (int'(to_cnt_q) == TIMEOUT_CYCLES - 1);
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_clr;
  assign unused_timeout_clr = timeout_clr_i;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl with default parameters.
module tb_clk_div_cfg_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] cfg_div_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [3:0] div_o;
  logic       div_valid_o;
  logic       div_ready_i;
  logic [3:0] cur_div_o;
  logic       busy_o;
  logic       pending_o;
  logic       timeout_o;
  logic       timeout_clr_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  clk_div_cfg_ctrl #(
    .DIV_VALUE_WIDTH  (4),
    .DEFAULT_DIV_VALUE(0),
    .SETTLE_CYCLES    (4),
    .TIMEOUT_CYCLES   (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_div_i    (cfg_div_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .div_o        (div_o),
    .div_valid_o  (div_valid_o),
    .div_ready_i  (div_ready_i),
    .cur_div_o    (cur_div_o),
    .busy_o       (busy_o),
    .pending_o    (pending_o),
    .timeout_o    (timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy_o; i++) tick();
    check(tag, 32'(busy_o), 0);
  endtask

  int valid_seen;

  initial begin
    rst_i         = 1'b1;
    cfg_div_i     = '0;
    cfg_valid_i   = 1'b0;
    div_ready_i   = 1'b1;
    timeout_clr_i = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b0;
    tick();

    // reset state
    check("rst_cur",     32'(cur_div_o),   0);
    check("rst_div",     32'(div_o),       0);
    check("rst_valid",   32'(div_valid_o), 0);
    check("rst_ready",   32'(cfg_ready_o), 1);
    check("rst_busy",    32'(busy_o),      0);
    check("rst_pending", 32'(pending_o),   0);
    check("rst_timeout", 32'(timeout_o),   0);

    // basic change to 5 with ready tied high
    cfg_div_i = 4'd5; cfg_valid_i = 1'b1;
    tick();                                   // edge N
    cfg_valid_i = 1'b0;
    check("chg_valid", 32'(div_valid_o), 1);
    check("chg_div",   32'(div_o),       5);
    check("chg_busy",  32'(busy_o),      1);
    tick();                                   // edge N+1 handshake
    check("chg_cur",       32'(cur_div_o),   5);
    check("chg_valid_low", 32'(div_valid_o), 0);
    check("settle_busy0",  32'(busy_o),      1);
    for (int i = 0; i < 3; i++) tick();       // edges N+2..N+4
    check("settle_busy3",  32'(busy_o),      1);
    tick();                                   // edge N+5
    check("settle_done",   32'(busy_o),      0);

    // redundant request is dropped
    cfg_div_i = 4'd5; cfg_valid_i = 1'b1;
    check("redund_ready", 32'(cfg_ready_o), 1);
    tick();
    cfg_valid_i = 1'b0;
    check("redund_valid", 32'(div_valid_o), 0);
    check("redund_busy",  32'(busy_o),      0);
    tick();
    check("redund_busy2", 32'(busy_o),      0);

    // back-to-back with downstream stalled, third request stalled
    div_ready_i = 1'b0;
    cfg_div_i = 4'd3; cfg_valid_i = 1'b1;
    tick();
    cfg_div_i = 4'd7;
    tick();
    check("pend_set",    32'(pending_o),   1);
    check("pend_ready",  32'(cfg_ready_o), 0);
    check("pend_div",    32'(div_o),       3);
    check("pend_valid",  32'(div_valid_o), 1);
    cfg_div_i = 4'd9;
    for (int i = 0; i < 3; i++) tick();
    cfg_valid_i = 1'b0;
    check("stall_pend",  32'(pending_o),   1);
    check("stall_div",   32'(div_o),       3);
    div_ready_i = 1'b1;
    tick();
    check("order_first", 32'(cur_div_o),   3);
    wait_idle("order_idle");
    check("order_cur",   32'(cur_div_o),   7);
    check("order_div",   32'(div_o),       7);
    check("order_pend",  32'(pending_o),   0);

    // pending value equal to the value in flight drains with no request
    div_ready_i = 1'b0;
    cfg_div_i = 4'd4; cfg_valid_i = 1'b1;
    tick();
    tick();
    cfg_valid_i = 1'b0;
    check("dup_pend", 32'(pending_o), 1);
    div_ready_i = 1'b1;
    tick();
    check("dup_cur", 32'(cur_div_o), 4);
    valid_seen = 0;
    for (int i = 0; i < 40 && busy_o; i++) begin
      tick();
      if (div_valid_o) valid_seen++;
    end
    check("dup_idle",     32'(busy_o),     0);
    check("dup_no_req",   32'(valid_seen), 0);
    check("dup_cur_hold", 32'(cur_div_o),  4);

    // stalled request and timeout flag
    div_ready_i = 1'b0;
    cfg_div_i = 4'd1; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("to_early", 32'(timeout_o), 0);
    for (int i = 0; i < 10; i++) tick();
`ifdef CLK_DIV_CFG_CTRL_TIMEOUT_EN
    check("to_set",      32'(timeout_o),   1);
    check("to_valid",    32'(div_valid_o), 1);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    check("to_clr",      32'(timeout_o),   0);
`else
    check("to_off",      32'(timeout_o),   0);
    check("to_valid",    32'(div_valid_o), 1);
`endif
    check("to_div", 32'(div_o), 1);

    // asynchronous reset mid-REQ with pending occupied
    cfg_div_i = 4'd6; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    check("mid_pend", 32'(pending_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid",   32'(div_valid_o), 0);
    check("arst_pend",    32'(pending_o),   0);
    check("arst_cur",     32'(cur_div_o),   0);
    check("arst_div",     32'(div_o),       0);
    check("arst_busy",    32'(busy_o),      0);
    check("arst_ready",   32'(cfg_ready_o), 1);
    check("arst_timeout", 32'(timeout_o),   0);
    tick();
    rst_i = 1'b0;
    tick();
    check("post_busy", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
